// File: rtl/sync_queue_mlane.sv
// Multi-lane synchronous FIFO with show-ahead read lanes, flush,
// occupancy count and a programmable almost-full hint.
module sync_queue_mlane #(
  parameter int WIDTH    = 97,
  parameter int DEPTH    = 8,
  parameter int LANES    = 2,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [LANES-1:0]       sync_q_wen,
  input  logic [LANES*WIDTH-1:0] sync_q_wdata,
  output logic [LANES-1:0]       sync_q_wok,
  input  logic [LANES-1:0]       sync_q_ren,
  output logic [LANES*WIDTH-1:0] sync_q_rdata,
  output logic [LANES-1:0]       sync_q_rok,
  input  logic                   sync_q_flush,
  output logic [CNT_W-1:0]       sync_q_count,
  output logic                   sync_q_afull
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] n_wr;
  logic [CNT_W-1:0] n_rd;
  logic [LANES-1:0] wr_acc;
  logic [LANES-1:0] rd_acc;
  logic             w_run;
  logic             r_run;

  assign free_cnt     = CNT_W'(DEPTH) - count;
  assign sync_q_count = count;
  assign sync_q_afull = count >= CNT_W'(AFULL_TH);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sync_q_wok[i] = free_cnt > CNT_W'(i);
    assign sync_q_rok[i] = count > CNT_W'(i);
    assign sync_q_rdata[i*WIDTH +: WIDTH] =
      mem[rd_ptr + PW'(i)];
  end

  // A lane only counts if every lower lane was also accepted.
  always_comb begin
    wr_acc = '0;
    rd_acc = '0;
    n_wr   = '0;
    n_rd   = '0;
    w_run  = 1'b1;
    r_run  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      w_run     = w_run & sync_q_wen[i] & sync_q_wok[i];
      r_run     = r_run & sync_q_ren[i] & sync_q_rok[i];
      wr_acc[i] = w_run;
      rd_acc[i] = r_run;
      n_wr      = n_wr + CNT_W'(w_run);
      n_rd      = n_rd + CNT_W'(r_run);
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && !sync_q_flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_acc[i]) begin
          mem[wr_ptr + PW'(i)] <=
            sync_q_wdata[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sync_q_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_wr);
      rd_ptr <= rd_ptr + PW'(n_rd);
      count  <= count + n_wr - n_rd;
    end
  end

endmodule

// File: tb/tb_sync_queue_mlane.sv
// Randomised bench for sync_queue_mlane against a queue-based
// reference model of the FIFO contents.
module tb_sync_queue_mlane;

  localparam int WIDTH = 97;
  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   CLK = 1'b0;
  logic                   RSTN;
  logic [LANES-1:0]       wen;
  logic [LANES*WIDTH-1:0] wdata;
  logic [LANES-1:0]       wok;
  logic [LANES-1:0]       ren;
  logic [LANES*WIDTH-1:0] rdata;
  logic [LANES-1:0]       rok;
  logic                   flush;
  logic [CNT_W-1:0]       count;
  logic                   afull;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q [$];
  int last_nw;
  int last_nr;

  sync_queue_mlane #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .sync_q_wen(wen),
    .sync_q_wdata(wdata),
    .sync_q_wok(wok),
    .sync_q_ren(ren),
    .sync_q_rdata(rdata),
    .sync_q_rok(rok),
    .sync_q_flush(flush),
    .sync_q_count(count),
    .sync_q_afull(afull)
  );

  always #5 CLK = ~CLK;

  function automatic logic [WIDTH-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [WIDTH-1:0] lane(
    input logic [LANES*WIDTH-1:0] v, input int i);
    return v[i*WIDTH +: WIDTH];
  endfunction

  // One clock: apply inputs, advance the model, leave bus idle.
  task automatic drive(input logic rst_n, input logic fl,
                       input logic [1:0] we,
                       input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1,
                       input logic [1:0] re);
    int sz;
    RSTN  = rst_n;
    flush = fl;
    wen   = we;
    ren   = re;
    wdata = {d1, d0};
    sz = q.size();
    last_nw = 0;
    last_nr = 0;
    if (rst_n && !fl) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i] && last_nw == i && DEPTH - sz > i) last_nw++;
        if (re[i] && last_nr == i && sz > i) last_nr++;
      end
    end
    @(posedge CLK);
    #1;
    if (!rst_n || fl) q.delete();
    else begin
      for (int i = 0; i < last_nr; i++) void'(q.pop_front());
      if (last_nw > 0) q.push_back(d0);
      if (last_nw > 1) q.push_back(d1);
    end
    RSTN  = 1'b1;
    flush = 1'b0;
    wen   = '0;
    ren   = '0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);
    checks++;
    if (count !== 0 || rok !== 2'b00 || wok !== 2'b11 ||
        afull !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d rok=%b wok=%b afull=%b",
               count, rok, wok, afull);
    end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] d;
    for (int i = 1; i <= DEPTH; i++) begin
      d = WIDTH'(i);
      drive(1'b1, 1'b0, 2'b01, d, rnd(), 2'b00);
      checks++;
      if (count !== CNT_W'(i) || afull !== (i >= 6)) begin
        errors++;
        $display("FAIL fill: count=%0d afull=%b want %0d/%b",
                 count, afull, i, i >= 6);
      end
    end
    checks++;
    if (wok !== 2'b00 || rok !== 2'b11) begin
      errors++;
      $display("FAIL full_flags: wok=%b rok=%b want 00/11",
               wok, rok);
    end
    checks++;
    if (lane(rdata, 0) !== 97'h1 || lane(rdata, 1) !== 97'h2) begin
      errors++;
      $display("FAIL fill_head: got %h %h want 1 2",
               lane(rdata, 0), lane(rdata, 1));
    end
  endtask

  task automatic test_partial_write();
    logic [WIDTH-1:0] a = rnd();
    logic [WIDTH-1:0] b = rnd();
    drive(1'b1, 1'b0, 2'b00, '0, '0, 2'b01);
    drive(1'b1, 1'b0, 2'b11, a, b, 2'b00);
    checks++;
    if (count !== 8 || lane(rdata, 0) !== 97'h2) begin
      errors++;
      $display("FAIL partial_wr: count=%0d head=%h want 8 2",
               count, lane(rdata, 0));
    end
    for (int n = 0; n < 8 && q.size() > 0; n++) begin
      checks++;
      if (lane(rdata, 0) !== q[0] || lane(rdata, 0) === b ||
          (q.size() > 1 && lane(rdata, 1) !== q[1])) begin
        errors++;
        $display("FAIL drain: got %h want %h",
                 lane(rdata, 0), q[0]);
      end
      drive(1'b1, 1'b0, 2'b00, '0, '0, 2'b11);
    end
    checks++;
    if (count !== 0 || rok !== 2'b00) begin
      errors++;
      $display("FAIL drained: count=%0d rok=%b want 0 00",
               count, rok);
    end
  endtask

  task automatic test_rw_same();
    logic [WIDTH-1:0] third;
    drive(1'b1, 1'b0, 2'b11, rnd(), rnd(), 2'b00);
    drive(1'b1, 1'b0, 2'b11, rnd(), rnd(), 2'b00);
    third = q[2];
    drive(1'b1, 1'b0, 2'b11, rnd(), rnd(), 2'b11);
    checks++;
    if (count !== 4 || lane(rdata, 0) !== third ||
        lane(rdata, 1) !== q[1]) begin
      errors++;
      $display("FAIL rw_same: count=%0d head=%h want 4 %h",
               count, lane(rdata, 0), third);
    end
  endtask

  task automatic test_lane1_only();
    logic [WIDTH-1:0] head;
    drive(1'b1, 1'b0, 2'b00, '0, '0, 2'b01);
    head = q[0];
    drive(1'b1, 1'b0, 2'b10, rnd(), rnd(), 2'b10);
    checks++;
    if (count !== 3 || lane(rdata, 0) !== head ||
        lane(rdata, 1) !== q[1]) begin
      errors++;
      $display("FAIL lane1_only: count=%0d head=%h want 3 %h",
               count, lane(rdata, 0), head);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 2'b11, rnd(), rnd(), 2'b00);
    checks++;
    if (count !== 5) begin
      errors++;
      $display("FAIL pre_flush: count=%0d want 5", count);
    end
    drive(1'b1, 1'b1, 2'b11, rnd(), rnd(), 2'b01);
    checks++;
    if (count !== 0 || rok !== 2'b00 || wok !== 2'b11) begin
      errors++;
      $display("FAIL flush: count=%0d rok=%b wok=%b want 0 00 11",
               count, rok, wok);
    end
    drive(1'b1, 1'b0, 2'b01, 97'hAA, rnd(), 2'b00);
    checks++;
    if (count !== 1 || lane(rdata, 0) !== 97'hAA ||
        rok !== 2'b01) begin
      errors++;
      $display("FAIL post_flush: count=%0d head=%h want 1 aa",
               count, lane(rdata, 0));
    end
  endtask

  task automatic test_wrap();
    int wseq = 0;
    int rseq = 0;
    int cyc = 0;
    logic [1:0] we;
    logic [1:0] re;
    drive(1'b1, 1'b1, 2'b00, '0, '0, 2'b00);
    while (rseq < 20 && cyc < 500) begin
      cyc++;
      we = 2'b00;
      if (wseq < 20 && $urandom_range(0, 3) != 0) begin
        we = (wseq < 19) ? 2'b11 : 2'b01;
      end
      re = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'b00;
      if (re[0] && rok[0]) begin
        checks++;
        if (lane(rdata, 0) !== WIDTH'(rseq + 100)) begin
          errors++;
          $display("FAIL wrap_data: got %h want %h",
                   lane(rdata, 0), WIDTH'(rseq + 100));
        end
      end
      drive(1'b1, 1'b0, we, WIDTH'(wseq + 100),
            WIDTH'(wseq + 101), re);
      wseq += last_nw;
      rseq += last_nr;
      if (count > 8 || count !== CNT_W'(q.size())) begin
        checks++;
        errors++;
        $display("FAIL wrap_count: got %0d want %0d",
                 count, q.size());
      end
    end
    checks++;
    if (rseq != 20 || count !== 0) begin
      errors++;
      $display("FAIL wrap_done: read %0d count=%0d want 20 0",
               rseq, count);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 2'b11, rnd(), rnd(), 2'b00);
    checks++;
    if (count !== 6 || afull !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: count=%0d afull=%b want 6 1",
               count, afull);
    end
    drive(1'b0, 1'b0, 2'b11, rnd(), rnd(), 2'b01);
    checks++;
    if (count !== 0 || rok !== 2'b00 || afull !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d rok=%b afull=%b",
               count, rok, afull);
    end
  endtask

  initial begin
    RSTN  = 1'b0;
    flush = 1'b0;
    wen   = '0;
    ren   = '0;
    wdata = '0;
    test_reset();
    test_fill();
    test_partial_write();
    test_rw_same();
    test_lane1_only();
    test_flush();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
